// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-dump constants and FSM state encoding
package mem_pkg;

  localparam int NUM_OF_BITS_DEF      = 16;
  localparam int NUM_OF_REGISTERS_DEF = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } dump_state_e;

endpackage

// File: rtl/mem_dump_if.sv
// rtl/mem_dump_if.sv - request, memory-read and output-stream signals of the dump engine
interface mem_dump_if #(
  parameter int Num_of_bits      = mem_pkg::NUM_OF_BITS_DEF,
  parameter int Num_of_registers = mem_pkg::NUM_OF_REGISTERS_DEF
) ();

  logic                        start;
  logic [Num_of_registers-1:0] base_addr;
  logic [Num_of_registers:0]   word_count;
  logic                        mem_rd_en;
  logic [Num_of_registers-1:0] mem_addr;
  logic [Num_of_bits-1:0]      mem_rd_data;
  logic [Num_of_bits-1:0]      out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        busy;
  logic                        done;

  modport slave (
    input  start, base_addr, word_count, mem_rd_data, out_ready,
    output mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done
  );

  modport master (
    output start, base_addr, word_count, mem_rd_data, out_ready,
    input  mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/mem_dump_fifo.sv
// rtl/mem_dump_fifo.sv - two-entry buffer between memory read data and the output stream
module mem_dump_fifo #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - streams a contiguous block of memory words out with a valid/ready handshake
module mem_dump import mem_pkg::*; #(
  parameter int Num_of_bits      = NUM_OF_BITS_DEF,
  parameter int Num_of_registers = NUM_OF_REGISTERS_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_dump_if.slave bus
);

  dump_state_e                 state_q, state_d;
  logic [Num_of_registers-1:0] addr_q, addr_d;
  logic [Num_of_registers:0]   rd_left_q, rd_left_d;
  logic [Num_of_registers:0]   out_left_q, out_left_d;
  logic                        inflight_q;

  logic [Num_of_bits-1:0]      fifo_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [1:0]                  fifo_count;
  logic [2:0]                  pending;

  logic                        rd_en, valid, pop, last, busy, done;
  logic [Num_of_bits-1:0]      data;

  // A read returns data next cycle, so an in-flight read already owns a FIFO slot.
  assign pending = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  mem_dump_fifo #(.Width(Num_of_bits)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (bus.mem_rd_data),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.word_count == '0) ? FINISH : RUN;
      RUN:     if (pop && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == RUN) && !fifo_empty;
    pop   = valid && bus.out_ready;
    last  = valid && (out_left_q == (Num_of_registers+1)'(1));
    rd_en = (state_q == RUN) && (rd_left_q != '0) && !fifo_full && (pending < 3'd2);
    busy  = (state_q != IDLE);
    done  = (state_q == FINISH);
    data  = valid ? fifo_data : '0;
  end

  always_comb begin
    addr_d     = addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    if ((state_q == IDLE) && bus.start) begin
      addr_d     = bus.base_addr;
      rd_left_d  = bus.word_count;
      out_left_d = bus.word_count;
    end else begin
      if (rd_en) begin
        addr_d    = addr_q + Num_of_registers'(1);
        rd_left_d = rd_left_q - (Num_of_registers+1)'(1);
      end
      if (pop) out_left_d = out_left_q - (Num_of_registers+1)'(1);
    end
  end

  // Clearing inflight_q on reset drops whatever data the memory returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      inflight_q <= rd_en;
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - directed table-driven bench for mem_dump
module tb_mem_dump;

  localparam int NB = 16;
  localparam int NR = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_dump_if #(.Num_of_bits(NB), .Num_of_registers(NR)) bus ();

  mem_dump #(.Num_of_bits(NB), .Num_of_registers(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] memval(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Memory model: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? memval(bus.mem_addr[15:0]) : 16'hBAD0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] base;
    logic [20:0] cnt;
    int          mode;
    logic [15:0] ef;
    logic [15:0] el;
    logic [19:0] ela;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  logic [19:0] rd_addrs[$];
  logic [15:0] words[$];
  bit          lasts[$];
  int          hs_cycs[$];
  int done_cnt = 0, done_cyc = 0, valid_cnt = 0;
  int stall_err = 0, occ_err = 0, last_err = 0;
  int issued = 0, popped = 0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  logic        nx_rst = 1'b1, nx_start = 1'b0;
  logic [19:0] nx_base = '0;
  logic [20:0] nx_cnt = '0;
  int          ready_mode = 0, rdy_idx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    if (bus.mem_rd_en) begin
      rd_addrs.push_back(bus.mem_addr);
      issued++;
    end
    if (bus.out_valid) valid_cnt++;
    if (bus.out_last && !bus.out_valid) last_err++;
    if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_err++;
    if (bus.out_valid && bus.out_ready) begin
      words.push_back(bus.out_data);
      lasts.push_back(bus.out_last);
      hs_cycs.push_back(cyc);
      popped++;
    end
    if (issued - popped > 2) occ_err++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (rst) begin
      popped     = issued;
      prev_stall = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst            = nx_rst;
    bus.start      = nx_start;
    bus.base_addr  = nx_base;
    bus.word_count = nx_cnt;
    bus.out_ready  = (ready_mode == 0) ? 1'b1 : ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3));
    rdy_idx++;
    @(negedge clk);
    sample();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"},  bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"},  bus.out_last, 0);
    chk({tag, "_data"},  bus.out_data, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
  endtask

  task automatic run_dump(input logic [19:0] base, input logic [20:0] cnt, input int mode,
                          input bit hold, input logic [15:0] ef, input logic [15:0] el,
                          input logic [19:0] ela, input string tag);
    int r0, w0, d0, v0, s0, o0, l0, sc, n, nw, nr;
    logic [19:0] a;
    r0 = rd_addrs.size(); w0 = words.size(); d0 = done_cnt; v0 = valid_cnt;
    s0 = stall_err; o0 = occ_err; l0 = last_err;
    ready_mode = mode; rdy_idx = 0;
    nx_base = base; nx_cnt = cnt; nx_start = 1'b1;
    tick();
    sc = cyc;
    if (!hold) nx_start = 1'b0;
    nx_base = ~base;
    nx_cnt  = 21'd5;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt > d0), 1);
    nx_start = 1'b0;
    repeat (4) tick();
    nr = rd_addrs.size() - r0;
    nw = words.size() - w0;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_reads"}, nr, cnt);
    chk({tag, "_words"}, nw, cnt);
    chk({tag, "_stall_stable"}, stall_err - s0, 0);
    chk({tag, "_outstanding"}, occ_err - o0, 0);
    chk({tag, "_last_no_valid"}, last_err - l0, 0);
    if (cnt == 0) begin
      chk({tag, "_no_valid"}, valid_cnt - v0, 0);
      chk({tag, "_done_cycle"}, done_cyc, sc + 1);
    end else if (nw > 0 && nr > 0) begin
      chk({tag, "_first_word"}, words[w0], ef);
      chk({tag, "_last_word"}, words[w0 + nw - 1], el);
      chk({tag, "_last_addr"}, rd_addrs[r0 + nr - 1], ela);
      for (int i = 0; i < int'(cnt); i++) begin
        a = base + 20'(i);
        if (i < nr) chk({tag, "_addr_order"}, rd_addrs[r0 + i], a);
        if (i < nw) begin
          chk({tag, "_word_order"}, words[w0 + i], memval(a[15:0]));
          chk({tag, "_last_flag"}, lasts[w0 + i], (i == int'(cnt) - 1));
        end
      end
      chk({tag, "_first_latency"}, (hs_cycs[w0] >= sc + 2), 1);
      if (mode == 0) chk({tag, "_back_to_back"}, hs_cycs[w0 + nw - 1] - hs_cycs[w0], nw - 1);
      chk({tag, "_done_cycle"}, done_cyc, hs_cycs[w0 + nw - 1] + 1);
    end
  endtask

  initial begin
    int r0, v0, d0, n;
    vecs[0] = '{20'h00004, 21'd3, 0, 16'hA004, 16'hA006, 20'h00006};
    vecs[1] = '{20'hFFFFE, 21'd4, 0, 16'h9FFE, 16'hA001, 20'h00001};
    vecs[2] = '{20'h00000, 21'd0, 0, 16'h0000, 16'h0000, 20'h00000};
    vecs[3] = '{20'h00010, 21'd8, 1, 16'hA010, 16'hA017, 20'h00017};
    vecs[4] = '{20'h00100, 21'd1, 1, 16'hA100, 16'hA100, 20'h00100};

    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    nx_rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++)
      run_dump(vecs[v].base, vecs[v].cnt, vecs[v].mode, 1'b0,
               vecs[v].ef, vecs[v].el, vecs[v].ela, $sformatf("vec%0d", v));

    // Reset wins over a simultaneous start.
    nx_rst = 1'b1; nx_start = 1'b1; nx_base = 20'h00300; nx_cnt = 21'd5;
    tick();
    nx_rst = 1'b0; nx_start = 1'b0;
    tick();
    chk("rst_prio_busy", bus.busy, 0);
    chk("rst_prio_rd_en", bus.mem_rd_en, 0);
    repeat (3) tick();

    // Reset in the cycle after the third read of a ten-word dump.
    ready_mode = 0;
    r0 = rd_addrs.size();
    nx_base = 20'h00040; nx_cnt = 21'd10; nx_start = 1'b1;
    tick();
    nx_start = 1'b0;
    n = 0;
    while (rd_addrs.size() - r0 < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_third_read", rd_addrs.size() - r0, 3);
    nx_rst = 1'b1;
    tick();
    nx_rst = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    v0 = valid_cnt; d0 = done_cnt;
    repeat (5) tick();
    chk("midrst_no_valid", valid_cnt - v0, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    run_dump(20'h00000, 21'd2, 0, 1'b0, 16'hA000, 16'hA001, 20'h00001, "post_rst");

    // Start held high for the whole dump is accepted once.
    run_dump(20'h00200, 21'd5, 0, 1'b1, 16'hA200, 16'hA204, 20'h00204, "hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter Num_of_bits, default 16, the memory word width.
REQ-002 SHALL have parameter Num_of_registers, default 20, the memory address width (depth 2**Num_of_registers).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  dump request, sampled only in IDLE.
REQ-006 SHALL have port base_addr  in  Num_of_registers  first word address, captured with start.
REQ-007 SHALL have port word_count  in  Num_of_registers+1  number of words to dump (0 to 2**Num_of_registers), captured with start.
REQ-008 SHALL have port mem_rd_en  out  1  memory read strobe.
REQ-009 SHALL have port mem_addr  out  Num_of_registers  memory read address.
REQ-010 SHALL have port mem_rd_data  in  Num_of_bits  read data, valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have port out_data  out  Num_of_bits  dumped word.
REQ-012 SHALL have port out_valid  out  1  out_data valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the word.
REQ-014 SHALL have port out_last  out  1  marks the final word of the dump.
REQ-015 SHALL have port busy  out  1  high while not IDLE.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FINISH; IDLE->RUN on start with word_count>0; IDLE->FINISH on start with word_count=0; RUN->FINISH on the out_last handshake; FINISH->IDLE unconditionally.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL issue reads to base_addr, base_addr+1, ... in order, address incrementing modulo 2**Num_of_registers (wraps from all-ones to 0).
REQ-020 SHALL issue exactly word_count reads per dump, the first in the cycle after start is sampled.
REQ-021 SHALL buffer read data in a 2-entry FIFO and assert mem_rd_en only when (FIFO occupancy + reads in flight - pop this cycle) < 2, so no data is ever dropped under backpressure.
REQ-022 SHALL present the FIFO head on out_data/out_valid; a word transfers when out_valid and out_ready are both high.
REQ-023 SHALL assert out_valid for the first word no earlier than 2 cycles after the start-sampling edge and, with out_ready held high, sustain one word per cycle thereafter.
REQ-024 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-025 SHALL assert out_last together with out_valid only on the word_count-th word.
REQ-026 SHALL pulse done for exactly one cycle in FINISH, i.e. the cycle after the last handshake, or the cycle after start with word_count=0 (no read, no output).
REQ-027 SHALL drive busy high in RUN and FINISH.
REQ-028 SHALL drive mem_rd_en low and out_valid low in IDLE and FINISH.

Reset
REQ-029 SHALL, on rst high at a clock edge, enter IDLE, empty the FIFO, clear in-flight read tracking, and drive mem_rd_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-030 SHALL discard mem_rd_data returning in the cycle after a mid-dump reset.
REQ-031 SHALL give rst priority over start in the same cycle.

Structure
REQ-032 SHALL place the default Num_of_bits/Num_of_registers constants and the FSM state encoding in the shared memory package mem_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module mem_dump_fifo (push, pop, full, empty, count).

Verification
REQ-034 SHALL cover: memory preloaded mem[i]=i+16'hA000, base_addr=4, word_count=3, out_ready=1 -> words A004, A005, A006 on consecutive cycles, out_last on A006, done one cycle later.
REQ-035 SHALL cover: base_addr=20'hFFFFE, word_count=4 -> addresses FFFFE, FFFFF, 00000, 00001 read in order.
REQ-036 SHALL cover: word_count=0 -> no mem_rd_en, no out_valid, done pulse the cycle after start.
REQ-037 SHALL cover: word_count=8, out_ready toggling 1,0,0,1 repeatedly -> all 8 words in order, none lost or duplicated, out_data stable while stalled, at most 2 reads outstanding+buffered.
REQ-038 SHALL cover: rst asserted in the cycle after the 3rd read of a 10-word dump -> next cycle all outputs at reset values, no further out_valid; a following start with base_addr=0, word_count=2 dumps mem[0], mem[1] correctly.
REQ-039 SHALL cover: start held high during a dump -> ignored; exactly one done per accepted start.
